sn76489_psg: RTL and testbench
==============================

Name: sn76489_psg

Overview:
- SN76489-style programmable sound generator: three square-wave tone channels, one LFSR noise channel, and 4-bit logarithmic attenuation per channel.
- Written through an 8-bit parallel bus with an active-low write strobe.
- Produces a 12-bit mixed sample, exposed as an 8-bit raw sample, a serial DAC stream (DAC7611-style) and five PWM outputs.
- Sits behind the user-project multiplexer, which routes it to the chip GPIOs.

Parameters:
- PWM_BITS, 8, width of the PWM ramp counter.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  8  write data byte.
- we_n  in  1  active-low write strobe; every cycle it is sampled low performs one write.
- raw_sample  out  8  mix[11:4].
- pwm  out  5  pwm[3:0] per channel (tone0, tone1, tone2, noise); pwm[4] is the mix.
- dac_dat  out  1  serial DAC data, MSB first.
- dac_clk  out  1  serial DAC shift clock; the DAC shifts on its rising edge.
- dac_le  out  1  DAC latch enable; the DAC latches on its rising edge; idle high.

Behaviour:
- Reset values:
  - periods 0; volumes 15 (silent); tone outputs 0; counters 0.
  - noise control 0; LFSR 16'h8000; latched register = tone0.
  - mix 0; raw_sample 0; pwm 0; dac_dat 0; dac_clk 0; dac_le 1; DAC engine idle.
- Write decode:
  - Latch byte, bit7=1, fields [6:5] channel, [4] type (1 = volume), [3:0] data.
    - Records the channel/type as the latched register.
    - Tone: period[3:0] = data. Volume: vol = data. Noise-channel tone type: noise control = data[2:0] and LFSR reset to 16'h8000.
  - Data byte, bit7=0, applies to the latched register.
    - Tone 0-2: period[9:4] = data_in[5:0].
    - Volume: vol = data_in[3:0].
    - Noise control: ctrl = data_in[2:0] and LFSR reset.
- Tone channel (10-bit period N, up-counter):
  - Each clock: if N != 0 and cnt >= N-1, then cnt = 0 and the output toggles; otherwise cnt increments.
  - Result: a square wave with a half-period of N clocks.
  - N = 0 holds the output at its current value.
  - A new N takes effect immediately through the compare.
- Noise channel:
  - ctrl[1:0] selects the shift period: 00 = 64 clocks, 01 = 128, 10 = 256, 11 = every tone2 toggle.
  - ctrl[2] = 1: white noise, feedback = lfsr[0]^lfsr[3].
  - ctrl[2] = 0: periodic noise, feedback = lfsr[0].
  - Shift: lfsr = {fb, lfsr[15:1]}. Noise output = lfsr[0].
- Attenuation:
  - Amplitude table, 10 bits, index vol 0..15: 1023, 812, 645, 512, 407, 323, 256, 204, 162, 128, 102, 81, 64, 51, 40, 0.
  - Values are floor(1023*10^(-vol/10)); vol 15 = off.
- Mix:
  - Registered each clock: mix = sum over the 4 channels of (output ? amp(vol) : 0).
  - 12-bit, cannot overflow (max 4092).
  - One-cycle latency from a channel toggle to mix/raw_sample.
- PWM:
  - Free-running 8-bit counter c.
  - pwm[i] = (c < amp_i[9:2]) when channel i output is high, else 0.
  - pwm[4] = (c < mix[11:4]).
- DAC engine:
  - When idle and mix != last_sent: capture mix, drive dac_le low, then send 12 bits MSB first.
  - Each bit takes 2 cycles: dac_dat = bit with dac_clk = 0, then dac_clk = 1.
  - After bit 0, drive dac_clk = 0 and dac_le = 1 (rising edge latches), set last_sent, and return to idle for at least 1 cycle.
  - Latency from a mix change while idle to the latch is ≤ 27 cycles.
  - Changes during a transfer are sent by the next transfer; only the latest value is sent.
- Reset mid-transfer: dac_le returns to 1 immediately and the transfer is abandoned.
- Simultaneous write and tone toggle: the toggle uses the old N this cycle; the new N applies next cycle.

Test Plan:
- Write 0xC0, 0x18, 0xD8 (tone2 N=384, vol 8); others silent.
  - raw_sample alternates 0x00/0x0A every 384 clocks.
  - 48 clocks after each rise, the DAC model holds 0x0A2.
- Write 0x80, 0x0C, 0x90 (tone0 N=192, vol 0).
  - raw_sample toggles 0x00 ↔ 0x3F exactly every 192 clocks.
  - The DAC holds 0x3FF.
- Write 0xE4, 0xF1 (white noise, rate 00, vol 1).
  - Noise-high intervals give raw_sample 0x32 and DAC 0x32C.
  - Zero-run lengths are multiples of 64 and not all equal over 10 runs.
- Write 0xE0 (periodic noise) → the noise output is high for 64 clocks once every 16 × 64 clocks.
- Enable three tones at vol 0 and noise at vol 0 → mix peak 4092, raw_sample 0xFF, no wrap.
- Assert rst_n low for 1 cycle mid-operation.
  - All outputs return to their reset values next cycle; raw_sample 0; dac_le 1.
  - Later writes work normally.

Source files
------------

// File: rtl/sn76489_psg.sv
// SN76489-style sound generator: three square-wave tones, one LFSR noise channel and
// 4-bit log attenuation, mixed to 12 bits and presented as raw byte, PWM and serial DAC stream.
module sn76489_psg #(
   parameter int PWM_BITS = 8
) (
   input  logic       wb_clk_i,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       we_n,
   output logic [7:0] raw_sample,
   output logic [4:0] pwm,
   output logic       dac_dat,
   output logic       dac_clk,
   output logic       dac_le
);

   typedef enum logic [1:0] {
      DAC_IDLE   = 2'd0,
      DAC_BIT_LO = 2'd1,
      DAC_BIT_HI = 2'd2
   } dac_state_t;

   function automatic logic [9:0] amp_of(input logic [3:0] vol);
      case (vol)
         4'd0:    amp_of = 10'd1023;
         4'd1:    amp_of = 10'd812;
         4'd2:    amp_of = 10'd645;
         4'd3:    amp_of = 10'd512;
         4'd4:    amp_of = 10'd407;
         4'd5:    amp_of = 10'd323;
         4'd6:    amp_of = 10'd256;
         4'd7:    amp_of = 10'd204;
         4'd8:    amp_of = 10'd162;
         4'd9:    amp_of = 10'd128;
         4'd10:   amp_of = 10'd102;
         4'd11:   amp_of = 10'd81;
         4'd12:   amp_of = 10'd64;
         4'd13:   amp_of = 10'd51;
         4'd14:   amp_of = 10'd40;
         default: amp_of = 10'd0;
      endcase
   endfunction

   logic [1:0]          latch_ch_r;
   logic                latch_vol_r;
   logic [2:0][9:0]     period_r;
   logic [3:0][3:0]     vol_r;
   logic [2:0][9:0]     tone_cnt_r;
   logic [2:0]          tone_out_r;
   logic [2:0]          noise_ctrl_r;
   logic [15:0]         lfsr_r;
   logic [7:0]          noise_div_r;
   logic [11:0]         mix_r;
   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [4:0]          pwm_r;

   logic [1:0]          wr_ch_s;
   logic                wr_vol_s;
   logic                noise_wr_s;
   logic [2:0]          tone_hit_s;
   logic                noise_shift_s;
   logic                noise_fb_s;
   logic [3:0]          chan_out_s;
   logic [3:0][9:0]     amp_s;
   logic [11:0]         mix_s;
   logic [4:0]          pwm_s;

   dac_state_t          dac_state_r, dac_state_s;
   logic [11:0]         dac_shift_r, dac_shift_s;
   logic [3:0]          dac_idx_r, dac_idx_s;
   logic [11:0]         last_sent_r, last_sent_s;
   logic                dac_dat_r, dac_dat_s;
   logic                dac_clk_r, dac_clk_s;
   logic                dac_le_r, dac_le_s;

   assign chan_out_s = {lfsr_r[0], tone_out_r};

   // Write decode, tone compares, noise clocking and next mix/PWM values
   always_comb begin
      wr_ch_s       = latch_ch_r;
      wr_vol_s      = latch_vol_r;
      tone_hit_s    = 3'b000;
      noise_shift_s = 1'b0;
      mix_s         = 12'd0;
      pwm_s         = 5'b00000;
      if (data_in[7]) begin
         wr_ch_s  = data_in[6:5];
         wr_vol_s = data_in[4];
      end else begin
         wr_ch_s  = latch_ch_r;
         wr_vol_s = latch_vol_r;
      end
      noise_wr_s = !we_n && !wr_vol_s && (wr_ch_s == 2'd3);
      for (int i = 0; i < 3; i++) begin
         tone_hit_s[i] = (period_r[i] != 10'd0) && (tone_cnt_r[i] >= period_r[i] - 10'd1);
      end
      case (noise_ctrl_r[1:0])
         2'b00:   noise_shift_s = (noise_div_r[5:0] == 6'h3F);
         2'b01:   noise_shift_s = (noise_div_r[6:0] == 7'h7F);
         2'b10:   noise_shift_s = (noise_div_r == 8'hFF);
         default: noise_shift_s = tone_hit_s[2];
      endcase
      noise_fb_s = noise_ctrl_r[2] ? (lfsr_r[0] ^ lfsr_r[3]) : lfsr_r[0];
      for (int i = 0; i < 4; i++) begin
         amp_s[i] = amp_of(vol_r[i]);
         if (chan_out_s[i]) begin
            mix_s = mix_s + {2'b00, amp_s[i]};
         end else begin
            mix_s = mix_s;
         end
         pwm_s[i] = chan_out_s[i] && (pwm_cnt_r < amp_s[i][9 -: PWM_BITS]);
      end
      pwm_s[4] = (pwm_cnt_r < mix_r[11 -: PWM_BITS]);
   end

   // Register file, tone counters and noise LFSR
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         latch_ch_r   <= 2'd0;
         latch_vol_r  <= 1'b0;
         period_r     <= {3{10'd0}};
         vol_r        <= {4{4'hF}};
         tone_cnt_r   <= {3{10'd0}};
         tone_out_r   <= 3'b000;
         noise_ctrl_r <= 3'd0;
         lfsr_r       <= 16'h8000;
         noise_div_r  <= 8'd0;
      end else begin
         noise_div_r <= noise_div_r + 8'd1;
         for (int i = 0; i < 3; i++) begin
            if (tone_hit_s[i]) begin
               tone_cnt_r[i] <= 10'd0;
               tone_out_r[i] <= ~tone_out_r[i];
            end else begin
               tone_cnt_r[i] <= tone_cnt_r[i] + 10'd1;
            end
            if (!we_n && !wr_vol_s && (wr_ch_s == 2'(i))) begin
               if (data_in[7]) begin
                  period_r[i][3:0] <= data_in[3:0];
               end else begin
                  period_r[i][9:4] <= data_in[5:0];
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (!we_n && wr_vol_s && (wr_ch_s == 2'(i))) begin
               vol_r[i] <= data_in[3:0];
            end
         end
         if (!we_n && data_in[7]) begin
            latch_ch_r  <= data_in[6:5];
            latch_vol_r <= data_in[4];
         end
         // A control write restarts the LFSR even if a shift was due this cycle
         if (noise_wr_s) begin
            noise_ctrl_r <= data_in[2:0];
            lfsr_r       <= 16'h8000;
         end else if (noise_shift_s) begin
            lfsr_r <= {noise_fb_s, lfsr_r[15:1]};
         end
      end
   end

   // Registered mix, PWM ramp and PWM comparator outputs
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         mix_r     <= 12'd0;
         pwm_cnt_r <= {PWM_BITS{1'b0}};
         pwm_r     <= 5'b00000;
      end else begin
         mix_r     <= mix_s;
         pwm_cnt_r <= pwm_cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
         pwm_r     <= pwm_s;
      end
   end

   // DAC serialiser next state: LE low with MSB, then two cycles per bit, latch on LE rise
   always_comb begin
      dac_state_s = dac_state_r;
      dac_shift_s = dac_shift_r;
      dac_idx_s   = dac_idx_r;
      last_sent_s = last_sent_r;
      dac_dat_s   = dac_dat_r;
      dac_clk_s   = dac_clk_r;
      dac_le_s    = dac_le_r;
      case (dac_state_r)
         DAC_IDLE: begin
            if (mix_r != last_sent_r) begin
               dac_shift_s = mix_r;
               dac_idx_s   = 4'd11;
               dac_dat_s   = mix_r[11];
               dac_clk_s   = 1'b0;
               dac_le_s    = 1'b0;
               dac_state_s = DAC_BIT_LO;
            end else begin
               dac_clk_s = 1'b0;
               dac_le_s  = 1'b1;
            end
         end
         DAC_BIT_LO: begin
            dac_clk_s   = 1'b1;
            dac_state_s = DAC_BIT_HI;
         end
         DAC_BIT_HI: begin
            if (dac_idx_r == 4'd0) begin
               dac_clk_s   = 1'b0;
               dac_le_s    = 1'b1;
               last_sent_s = dac_shift_r;
               dac_state_s = DAC_IDLE;
            end else begin
               dac_idx_s   = dac_idx_r - 4'd1;
               dac_dat_s   = dac_shift_r[dac_idx_r - 4'd1];
               dac_clk_s   = 1'b0;
               dac_state_s = DAC_BIT_LO;
            end
         end
         default: begin
            dac_clk_s   = 1'b0;
            dac_le_s    = 1'b1;
            dac_state_s = DAC_IDLE;
         end
      endcase
   end

   // DAC serialiser state register
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         dac_state_r <= DAC_IDLE;
         dac_shift_r <= 12'd0;
         dac_idx_r   <= 4'd0;
         last_sent_r <= 12'd0;
         dac_dat_r   <= 1'b0;
         dac_clk_r   <= 1'b0;
         dac_le_r    <= 1'b1;
      end else begin
         dac_state_r <= dac_state_s;
         dac_shift_r <= dac_shift_s;
         dac_idx_r   <= dac_idx_s;
         last_sent_r <= last_sent_s;
         dac_dat_r   <= dac_dat_s;
         dac_clk_r   <= dac_clk_s;
         dac_le_r    <= dac_le_s;
      end
   end

   assign raw_sample = mix_r[11:4];
   assign pwm        = pwm_r;
   assign dac_dat    = dac_dat_r;
   assign dac_clk    = dac_clk_r;
   assign dac_le     = dac_le_r;

endmodule

// File: tb/tb_sn76489_psg.sv
// Bench for sn76489_psg: a reference model pushes expected samples and DAC words into
// queues each clock; a monitor pops them and compares against the DUT outputs.
module tb_sn76489_psg;

   logic       wb_clk_i = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       we_n;
   logic [7:0] raw_sample;
   logic [4:0] pwm;
   logic       dac_dat;
   logic       dac_clk;
   logic       dac_le;

   int checks = 0;
   int errors = 0;
   int phase  = 0;
   int ph_raw_max [8];
   int ph_dac_max [8];

   logic [12:0] out_q [$];   // {pwm, raw_sample}
   logic [12:0] dac_q [$];   // {abort, word}

   sn76489_psg #(.PWM_BITS(8)) dut (
      .wb_clk_i   (wb_clk_i),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .we_n       (we_n),
      .raw_sample (raw_sample),
      .pwm        (pwm),
      .dac_dat    (dac_dat),
      .dac_clk    (dac_clk),
      .dac_le     (dac_le)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // floor(1023 * 10^(-vol/10)), vol 15 silent
   function automatic int amp_model(input int v);
      if (v >= 15) return 0;
      return $rtoi(1023.0 * (10.0 ** (-v / 10.0)));
   endfunction

   // Behavioural reference model, advanced once per rising edge
   initial begin : ref_model
      int per [3];
      int vol [4];
      int cnt [3];
      bit tout [3];
      bit ch_on [4];
      int ctrl, div, pc, mix, nmix, lch, d_val, d_last, a;
      bit lvol, d_pend, t2, shift, nwr, fb;
      logic [15:0] lfsr;
      logic [4:0]  npwm;
      longint e, d_free, d_latch;
      e = 0; d_free = 0; d_latch = 0; d_pend = 0; d_val = 0; d_last = 0;
      forever begin
         @(posedge wb_clk_i);
         e++;
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin per[i] = 0; cnt[i] = 0; tout[i] = 0; end
            for (int i = 0; i < 4; i++) vol[i] = 15;
            ctrl = 0; lfsr = 16'h8000; div = 0; pc = 0; mix = 0; lch = 0; lvol = 0;
            if (d_pend) dac_q.push_back({1'b1, 12'h000});
            d_pend = 0; d_last = 0; d_free = e + 1;
            out_q.push_back(13'h0000);
         end else begin
            for (int i = 0; i < 3; i++) ch_on[i] = tout[i];
            ch_on[3] = lfsr[0];
            nmix = 0; npwm = 5'b00000;
            for (int i = 0; i < 4; i++) begin
               a = amp_model(vol[i]);
               if (ch_on[i]) begin
                  nmix += a;
                  npwm[i] = (pc < a / 4);
               end
            end
            npwm[4] = (pc < mix / 16);
            // DAC: capture when idle and changed; latch 24 edges later
            if (d_pend && e == d_latch) begin
               dac_q.push_back({1'b0, d_val[11:0]});
               d_pend = 0; d_last = d_val; d_free = e + 1;
            end else if (!d_pend && e >= d_free && mix != d_last) begin
               d_pend = 1; d_val = mix; d_latch = e + 24;
            end
            t2 = 0;
            for (int i = 0; i < 3; i++) begin
               if (per[i] != 0 && cnt[i] >= per[i] - 1) begin
                  cnt[i] = 0; tout[i] = !tout[i];
                  if (i == 2) t2 = 1;
               end else begin
                  cnt[i] = (cnt[i] + 1) % 1024;
               end
            end
            if (ctrl % 4 == 3) shift = t2;
            else shift = ((div + 1) % (64 << (ctrl % 4))) == 0;
            div = (div + 1) % 256;
            pc  = (pc + 1) % 256;
            nwr = 0;
            if (!we_n) begin
               if (data_in[7]) begin lch = int'(data_in[6:5]); lvol = data_in[4]; end
               if (lvol) vol[lch] = int'(data_in[3:0]);
               else if (lch == 3) begin ctrl = int'(data_in[2:0]); lfsr = 16'h8000; nwr = 1; end
               else if (data_in[7]) per[lch] = (per[lch] & 32'h3F0) | int'(data_in[3:0]);
               else per[lch] = (per[lch] & 32'h00F) | (int'(data_in[5:0]) * 16);
            end
            if (!nwr && shift) begin
               fb = (ctrl >= 4) ? (lfsr[0] ^ lfsr[3]) : lfsr[0];
               lfsr = {fb, lfsr[15:1]};
            end
            mix = nmix;
            out_q.push_back({npwm, nmix[11:4]});
         end
      end
   end

   // Monitor: pops expectations and decodes the serial DAC stream
   initial begin : monitor
      logic [12:0] want;
      logic [11:0] word;
      int nbits;
      logic prev_clk, prev_le, latch;
      for (int i = 0; i < 8; i++) begin ph_raw_max[i] = 0; ph_dac_max[i] = 0; end
      word = 12'h000; nbits = 0; prev_clk = 1'b0; prev_le = 1'b1;
      forever begin
         @(negedge wb_clk_i);
         if (out_q.size() > 0) begin
            want = out_q.pop_front();
            checks++;
            if (raw_sample !== want[7:0]) begin
               errors++;
               $display("FAIL raw_sample: got %h expected %h at %0t", raw_sample, want[7:0], $time);
            end
            checks++;
            if (pwm !== want[12:8]) begin
               errors++;
               $display("FAIL pwm: got %b expected %b at %0t", pwm, want[12:8], $time);
            end
            if (int'(raw_sample) > ph_raw_max[phase]) ph_raw_max[phase] = int'(raw_sample);
         end
         if (dac_clk === 1'b1 && prev_clk === 1'b0) begin
            word = {word[10:0], dac_dat};
            nbits++;
         end
         if (dac_le === 1'b0 && prev_le === 1'b1) begin
            word = 12'h000; nbits = 0;
         end
         latch = (dac_le === 1'b1 && prev_le === 1'b0);
         if (dac_q.size() > 0) begin
            want = dac_q.pop_front();
            checks++;
            if (!latch) begin
               errors++;
               $display("FAIL dac_latch_time: got le=%b expected rising edge at %0t", dac_le, $time);
            end else if (!want[12]) begin
               if (word !== want[11:0] || nbits != 12) begin
                  errors++;
                  $display("FAIL dac_word: got %h (%0d bits) expected %h (12 bits) at %0t",
                           word, nbits, want[11:0], $time);
               end
               if (int'(word) > ph_dac_max[phase]) ph_dac_max[phase] = int'(word);
            end
         end else if (latch) begin
            checks++; errors++;
            $display("FAIL dac_unexpected_latch: got word %h expected no latch at %0t", word, $time);
         end
         prev_clk = dac_clk;
         prev_le  = dac_le;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   task automatic wr(input logic [7:0] b);
      @(negedge wb_clk_i);
      data_in = b; we_n = 1'b0;
      @(negedge wb_clk_i);
      we_n = 1'b1;
   endtask

   task automatic pulse_reset();
      @(negedge wb_clk_i);
      rst_n = 1'b0; we_n = 1'b1;
      @(negedge wb_clk_i);
      rst_n = 1'b1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Directed phases from the test plan, then randomized writes with a mid-transfer reset
   initial begin : driver
      logic [7:0] b;
      bit did_rst;
      rst_n = 1'b0; we_n = 1'b1; data_in = 8'h00;
      idle(2);
      rst_n = 1'b1;

      phase = 1;
      wr(8'hC0); wr(8'h18); wr(8'hD8);
      idle(2000);
      chk("tone2_raw_peak", ph_raw_max[1], 32'h0A);
      chk("tone2_dac_peak", ph_dac_max[1], 32'h0A2);

      pulse_reset(); phase = 2;
      wr(8'h80); wr(8'h0C); wr(8'h90);
      idle(1000);
      chk("tone0_raw_peak", ph_raw_max[2], 32'h3F);
      chk("tone0_dac_peak", ph_dac_max[2], 32'h3FF);

      pulse_reset(); phase = 3;
      wr(8'hE4); wr(8'hF1);
      idle(6000);
      chk("white_raw_peak", ph_raw_max[3], 32'h32);
      chk("white_dac_peak", ph_dac_max[3], 32'h32C);

      pulse_reset(); phase = 4;
      wr(8'hE0); wr(8'hF0);
      idle(2500);
      chk("periodic_raw_peak", ph_raw_max[4], 32'h3F);

      pulse_reset(); phase = 5;
      wr(8'h90); wr(8'hB0); wr(8'hD0); wr(8'hF0); wr(8'hE0);
      wr(8'h81); wr(8'hA1); wr(8'hC1);
      idle(1500);
      chk("full_mix_raw_peak", ph_raw_max[5], 32'hFF);

      phase = 6; did_rst = 0;
      for (int n = 0; n < 24000; n++) begin
         @(negedge wb_clk_i);
         if (rst_n == 1'b0) begin
            chk("post_reset_raw", int'(raw_sample), 0);
            chk("post_reset_pwm", int'(pwm), 0);
            chk("post_reset_dac_le", int'(dac_le), 1);
            rst_n = 1'b1;
         end else if (n >= 12000 && !did_rst && dac_le == 1'b0) begin
            rst_n = 1'b0; we_n = 1'b1; did_rst = 1;
         end else if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom);
            if (!b[7] && $urandom_range(0, 3) != 0) b = b & 8'h03;
            data_in = b; we_n = 1'b0;
         end else begin
            we_n = 1'b1;
         end
      end
      we_n = 1'b1;
      if (!did_rst) begin
         checks++; errors++;
         $display("FAIL reset_window_timeout: got no DAC transfer to interrupt expected one");
      end
      idle(40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
